// File: rtl/key_event_sequencer.sv
// Purpose: parses PS/2 make/break/extended scan codes, keeps a 4-deep release history, drives a 4-digit multiplexed display.
// Latency: key_event one cycle after the completing byte; display outputs lag idx/history changes by one cycle.
// Backpressure: none; every valid_code strobe is consumed, back-to-back bytes accepted every cycle.
module key_event_sequencer #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_code,
    input  logic [7:0] scan_code_in,
    output logic [7:0] code_to_display,
    output logic       ext_flag,
    output logic [3:0] seg_en,
    output logic       key_event,
    output logic [8:0] key_event_code
);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam int         CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            push;
    logic [8:0]      push_dat;
    logic [3:0][8:0] slots;
    logic [CW-1:0]   div_cnt;
    logic [1:0]      idx;
    logic [8:0]      cur_slot;

    // Parser state register; a reset drops any partially received prefix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: E0 always (re)enters EXT, F0 arms the break, anything else returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (valid_code) begin
            if (scan_code_in == CODE_EXT) begin
                state_nxt = EXT;
            end else if (scan_code_in == CODE_BRK) begin
                state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // Output decode: a non-prefix, non-zero byte completing a break becomes a history entry.
    always_comb begin
        push     = 1'b0;
        push_dat = {(state == EXT_BRK), scan_code_in};
        if (valid_code && (state == BRK || state == EXT_BRK) &&
            scan_code_in != CODE_EXT && scan_code_in != CODE_BRK &&
            scan_code_in != 8'h00) begin
            push = 1'b1;
        end
    end

    // History shift register plus the one-cycle release pulse and held last code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots          <= '0;
            key_event      <= 1'b0;
            key_event_code <= 9'd0;
        end else begin
            key_event <= push;
            if (push) begin
                slots          <= {slots[2:0], push_dat};
                key_event_code <= push_dat;
            end
        end
    end

    // Refresh scheduler: each digit is held for REFRESH_DIV cycles, free-running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign cur_slot = slots[idx];

    // Registered digit drive from the pre-edge idx/history; empty slots blank the digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_en          <= 4'b1111;
            code_to_display <= 8'd0;
            ext_flag        <= 1'b0;
        end else if (cur_slot != 9'd0) begin
            seg_en          <= ~(4'b0001 << idx);
            code_to_display <= cur_slot[7:0];
            ext_flag        <= cur_slot[8];
        end else begin
            seg_en          <= 4'b1111;
            code_to_display <= 8'd0;
            ext_flag        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_sequencer.sv
module tb_key_event_sequencer;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       valid_code;
    logic [7:0] scan_code_in;
    logic [7:0] code_to_display;
    logic       ext_flag;
    logic [3:0] seg_en;
    logic       key_event;
    logic [8:0] key_event_code;

    int tests = 0;
    int fails = 0;

    key_event_sequencer #(.REFRESH_DIV(DIV)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_code      (valid_code),
        .scan_code_in    (scan_code_in),
        .code_to_display (code_to_display),
        .ext_flag        (ext_flag),
        .seg_en          (seg_en),
        .key_event       (key_event),
        .key_event_code  (key_event_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [8:0] hist[$];        // newest first, at most 4 entries
    logic [8:0] ev_q[$];        // expected key_event_code per release
    int         cyc_m  = 0;     // cycles since reset release
    bit         pre_ext = 0;
    bit         pre_brk = 0;
    logic [3:0] exp_seg = 4'b1111;
    logic [7:0] exp_code = 8'd0;
    logic       exp_ext = 1'b0;
    logic       exp_ke = 1'b0;
    logic [8:0] exp_kec = 9'd0;
    int         ev_count = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                hist.delete();
                ev_q.delete();
                cyc_m = 0; pre_ext = 0; pre_brk = 0;
                exp_seg = 4'b1111; exp_code = 8'd0; exp_ext = 1'b0;
                exp_ke = 1'b0; exp_kec = 9'd0;
            end else begin
                int         d;
                logic [8:0] ent;
                d   = (cyc_m / DIV) % 4;
                ent = (d < hist.size()) ? hist[d] : 9'd0;
                if (ent != 9'd0) begin
                    exp_seg  = 4'b1111 & ~(4'b0001 << d);
                    exp_code = ent[7:0];
                    exp_ext  = ent[8];
                end else begin
                    exp_seg = 4'b1111; exp_code = 8'd0; exp_ext = 1'b0;
                end
                exp_ke = 1'b0;
                if (valid_code) begin
                    if (scan_code_in == 8'hE0) begin
                        pre_ext = 1; pre_brk = 0;
                    end else if (scan_code_in == 8'hF0) begin
                        pre_brk = 1;
                    end else begin
                        if (pre_brk && scan_code_in != 8'h00) begin
                            logic [8:0] e;
                            e = {pre_ext, scan_code_in};
                            hist.push_front(e);
                            if (hist.size() > 4) void'(hist.pop_back());
                            ev_q.push_back(e);
                            exp_ke = 1'b1;
                            exp_kec = e;
                        end
                        pre_ext = 0; pre_brk = 0;
                    end
                end
                cyc_m++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("seg_en", int'(seg_en), int'(exp_seg));
            check("code_to_display", int'(code_to_display), int'(exp_code));
            check("ext_flag", int'(ext_flag), int'(exp_ext));
            check("key_event", int'(key_event), int'(exp_ke));
            check("key_event_code", int'(key_event_code), int'(exp_kec));
            if (key_event === 1'b1) begin
                if (ev_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_event at %0t: got code %0h expected none", $time, key_event_code);
                end else begin
                    logic [8:0] e;
                    e = ev_q.pop_front();
                    ev_count++;
                    check("event_pop", int'(key_event_code), int'(e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        valid_code   = 1'b1;
        scan_code_in = b;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_code = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic release_key(input logic [7:0] b);
        put(8'hF0);
        put(b);
        idle(1);
    endtask

    initial begin
        rst = 1'b1; valid_code = 1'b0; scan_code_in = 8'd0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // idle after reset: blank display, no events
        idle(32);

        // plain release, then history walk across all digits
        put(8'h1C); put(8'hF0); put(8'h1C); idle(20);
        put(8'hE0); put(8'h75); put(8'hE0); put(8'hF0); put(8'h75); idle(20);
        release_key(8'h1C); release_key(8'h32); release_key(8'h21);
        release_key(8'h23); release_key(8'h24);
        idle(36);

        // resync on E0 inside a break, and a 00 break
        put(8'hF0); put(8'hE0); put(8'hF0); put(8'h6B); idle(4);
        put(8'hF0); put(8'h00); put(8'h1C); idle(20);

        // reset between F0 and the completing byte
        put(8'hF0); idle(1);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        put(8'h1C); idle(36);

        // randomized byte stream with random gaps (including back-to-back)
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r < 5)  b = 8'hF0;
            else if (r == 5) b = 8'h00;
            else             b = 8'($urandom_range(1, 255));
            put(b);
            r = $urandom_range(0, 3);
            if (r != 0) idle(r);
        end
        idle(40);

        tests++;
        if (ev_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d left expected 0", ev_q.size());
        end
        tests++;
        if (ev_count < 10) begin
            fails++;
            $display("FAIL event_coverage: got %0d events expected at least 10", ev_count);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
